hmem_arb: RTL and testbench
===========================

// Module: hmem_arb
// PURPOSE
//  Arbitrates the single external line bus (h_*) between the L1i refill port
//  and the L1d refill/writeback ports inside a hart. Sits between the L1
//  caches and the hart's external memory interface.
//  Serializes requests, registers the bus command and returns line data with
//  a one-cycle valid pulse to the winning requester.
// PARAMETERS
//  LINE_W   256  cache line width in bits (matches hmem line)
//  ADDR_W   64   byte address width
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       asynchronous reset, active-high
//  i_addr      in   ADDR_W  L1i line address
//  i_rd        in   1       L1i refill request, held until i_dv
//  i_data      out  LINE_W  refill line to L1i
//  i_dv        out  1       1-cycle pulse, i_data valid
//  d_addr      in   ADDR_W  L1d line address
//  d_rd        in   1       L1d refill request, held until d_dv
//  d_wr        in   1       L1d writeback request, held until d_dv
//  d_wdata     in   LINE_W  writeback line
//  d_rdata     out  LINE_W  refill line to L1d
//  d_dv        out  1       1-cycle pulse, read data valid / write done
//  h_addr      out  ADDR_W  external line address, registered
//  h_rd        out  1       external read strobe, level, registered
//  h_wr        out  1       external write strobe, level, registered
//  h_data_out  out  LINE_W  external write data, registered
//  h_data_in   in   LINE_W  external read data
//  h_dv        in   1       external 1-cycle completion pulse (read or write)
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, all outputs 0, rr pointer = I.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: select winner from sampled requests; on any request go BUSY,
//     load h_addr/h_data_out, assert h_rd or h_wr from the next cycle.
//   BUSY: hold h_* stable until h_dv=1; then capture h_data_in into the
//     winner's data register, drop h_rd/h_wr, go RESP.
//   RESP: pulse the winner's dv for exactly one cycle; go IDLE.
//  Priority: d_wr highest (dirty writeback before any refill); then
//   round-robin between i_rd and d_rd; pointer flips to the other reader
//   after each granted read; a write does not move the pointer.
//  d_rd and d_wr together: write served first, read in a later grant.
//  Latency: request sampled in IDLE at edge N -> h_rd/h_wr high at N+1;
//   h_dv sampled at edge M -> dv pulse during cycle M+1; min 3 cycles.
//  Requests are sampled only in IDLE; requester must deassert on the cycle
//   after its dv. RESP->IDLE gap guarantees no double grant.
//  h_dv in IDLE or RESP: ignored. Request dropped while BUSY: transaction
//   completes, dv still pulses, data discarded by requester.
//  i_data/d_rdata hold last captured line until the next capture.
//  d_dv for a write: d_rdata unchanged.
//  Reset mid-transaction: transaction abandoned, h_rd/h_wr drop at once.
//  No timeout; a missing h_dv stalls the arbiter indefinitely.
// TESTING
//  1. i_rd=1, i_addr=0x1000; h_dv 4 cyc after h_rd with data 0xA5.. ->
//     h_addr=0x1000, h_rd high 1 cyc after req, i_dv 1 cyc after h_dv,
//     i_data=0xA5.., d_dv never high.
//  2. i_rd and d_rd both high from reset -> I granted first, then D;
//     repeat with both held -> grants alternate I,D,I,D.
//  3. d_wr=1 d_rd=1 i_rd=1, d_addr=0x2040 -> first h_wr with
//     h_data_out=d_wdata, then read grants in round-robin order.
//  4. h_dv pulsed while IDLE -> no dv output, state stays IDLE.
//  5. rst asserted 2 cyc into BUSY -> h_rd=0, i_dv=d_dv=0 immediately;
//     new i_rd after release served normally.
//  6. back-to-back i_rd with 0-cycle gap -> exactly one i_dv per request,
//     h_rd low for >=1 cycle between transactions.

Source files
------------

// File: rtl/hmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : hmem_arb
// Purpose  : Arbitrates the external line bus between L1i refill and L1d
//            refill/writeback, returning line data with a one-cycle dv pulse.
// Revision : 1.0 - initial release
// ============================================================================
module hmem_arb #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  output logic [LINE_W-1:0] i_data,
  output logic              i_dv,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_dv,
  output logic [ADDR_W-1:0] h_addr,
  output logic              h_rd,
  output logic              h_wr,
  output logic [LINE_W-1:0] h_data_out,
  input  logic [LINE_W-1:0] h_data_in,
  input  logic              h_dv
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  logic   rr_q;       // 0: L1i wins a read tie, 1: L1d wins
  logic   sel_l1d_q;
  logic   sel_wr_q;

  logic grant_any;
  logic grant_l1d;
  logic grant_wr;

  // Dirty writeback always goes first; reads tie-break on the rr pointer.
  always_comb begin
    grant_any = d_wr | d_rd | i_rd;
    grant_wr  = d_wr;
    grant_l1d = d_wr | (d_rd & (~i_rd | rr_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      sel_l1d_q  <= 1'b0;
      sel_wr_q   <= 1'b0;
      i_data     <= '0;
      i_dv       <= 1'b0;
      d_rdata    <= '0;
      d_dv       <= 1'b0;
      h_addr     <= '0;
      h_rd       <= 1'b0;
      h_wr       <= 1'b0;
      h_data_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            state_q   <= BUSY;
            sel_l1d_q <= grant_l1d;
            sel_wr_q  <= grant_wr;
            h_addr    <= grant_l1d ? d_addr : i_addr;
            h_rd      <= ~grant_wr;
            h_wr      <= grant_wr;
            if (grant_wr) begin
              h_data_out <= d_wdata;
            end else begin
              rr_q <= ~grant_l1d;
            end
          end
        end
        BUSY: begin
          if (h_dv) begin
            state_q <= RESP;
            h_rd    <= 1'b0;
            h_wr    <= 1'b0;
            if (!sel_l1d_q) begin
              i_data <= h_data_in;
              i_dv   <= 1'b1;
            end else begin
              if (!sel_wr_q) begin
                d_rdata <= h_data_in;
              end
              d_dv <= 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          i_dv    <= 1'b0;
          d_dv    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hmem_arb
// Purpose  : Scoreboard bench for hmem_arb with a reactive external memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hmem_arb;
  localparam int LW = 256;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_addr = '0;
  logic          i_rd = 1'b0;
  logic [LW-1:0] i_data;
  logic          i_dv;
  logic [AW-1:0] d_addr = '0;
  logic          d_rd = 1'b0;
  logic          d_wr = 1'b0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_dv;
  logic [AW-1:0] h_addr;
  logic          h_rd;
  logic          h_wr;
  logic [LW-1:0] h_data_out;
  logic [LW-1:0] h_data_in = '0;
  logic          h_dv = 1'b0;

  hmem_arb #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_dv(d_dv),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_data_out(h_data_out),
    .h_data_in(h_data_in), .h_dv(h_dv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
  } bus_t;

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [LW-1:0] data;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;
  int   i_pend = 0;
  int   drp = 0;
  int   dwp = 0;
  bit   spur = 1'b0;

  // memory-model state
  bit   m_active = 1'b0;
  bit   m_prev_cmd = 1'b0;
  int   m_cnt = 0;
  bus_t m_cur;
  rsp_t r_cur;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pat(input logic [7:0] b);
    return {(LW/8){b}};
  endfunction

  task automatic drive();
    i_rd = (i_pend > 0);
    d_rd = (drp > 0);
    d_wr = (dwp > 0);
  endtask

  task automatic exp_bus(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                         input logic [LW-1:0] rd, input int lat);
    bus_t b;
    b.wr = wr; b.addr = a; b.wdata = wd; b.rdata = rd; b.lat = lat;
    bus_q.push_back(b);
  endtask

  task automatic exp_rsp(input bit is_d, input bit wr, input logic [LW-1:0] data);
    rsp_t r;
    r.is_d = is_d; r.wr = wr; r.data = data;
    rsp_q.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_pend = 0; drp = 0; dwp = 0;
    drive();
    bus_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", LW'(rsp_q.size() + bus_q.size()), '0);
    repeat (3) @(posedge clk);
    #2 chk("pending_left", LW'(i_pend + drp + dwp), '0);
  endtask

  // External memory: checks each command and answers after its latency.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 1'b0; m_prev_cmd = 1'b0; h_dv = 1'b0;
        continue;
      end
      if (h_dv) begin
        h_dv = 1'b0;
        m_active = 1'b0;
        chk("bus_drop_after_hdv", LW'({h_rd, h_wr}), '0);
      end else if (!m_active && (h_rd || h_wr)) begin
        m_active = 1'b1;
        chk("bus_gap_before_cmd", LW'(m_prev_cmd), '0);
        if (bus_q.size() == 0) begin
          chk("unexpected_cmd", LW'(1), '0);
          m_cur.wr = h_wr; m_cur.addr = h_addr; m_cur.wdata = h_data_out;
          m_cur.rdata = '0; m_cur.lat = 1;
        end else begin
          m_cur = bus_q.pop_front();
          chk("h_wr", LW'(h_wr), LW'(m_cur.wr));
          chk("h_rd", LW'(h_rd), LW'(!m_cur.wr));
          chk("h_addr", LW'(h_addr), LW'(m_cur.addr));
          if (m_cur.wr) chk("h_data_out", h_data_out, m_cur.wdata);
        end
        m_cnt = m_cur.lat - 1;
        if (m_cnt <= 0) begin
          h_dv = 1'b1; h_data_in = m_cur.rdata;
        end
      end else if (m_active) begin
        m_cnt--;
        if (m_cnt <= 0) begin
          chk("h_addr_held", LW'(h_addr), LW'(m_cur.addr));
          h_dv = 1'b1; h_data_in = m_cur.rdata;
        end
      end else if (spur) begin
        spur = 1'b0;
        h_dv = 1'b1; h_data_in = pat(8'hEE);
      end
      m_prev_cmd = h_rd | h_wr;
    end
  end

  // Response monitor: pops the scoreboard on every dv pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (i_dv && d_dv) chk("dual_dv", LW'(1), '0);
      if (i_dv) begin
        if (rsp_q.size() == 0) chk("unexpected_i_dv", LW'(1), '0);
        else begin
          r_cur = rsp_q.pop_front();
          chk("i_dv_port", LW'(r_cur.is_d), '0);
          chk("i_data", i_data, r_cur.data);
        end
        if (i_pend > 0) i_pend--;
      end
      if (d_dv) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_d_dv", LW'(1), '0);
          if (drp > 0) drp--;
        end else begin
          r_cur = rsp_q.pop_front();
          chk("d_dv_port", LW'(r_cur.is_d), LW'(1));
          chk("d_rdata", d_rdata, r_cur.data);
          if (r_cur.wr) begin
            if (dwp > 0) dwp--;
          end else if (drp > 0) drp--;
        end
      end
      drive();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", LW'({i_dv, d_dv, h_rd, h_wr}), '0);
    chk("rst_h_addr", LW'(h_addr), '0);
    chk("rst_i_data", i_data, '0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_h_data_out", h_data_out, '0);
    #1 rst = 1'b0;

    // Single L1i refill with 4-cycle memory latency
    @(posedge clk); #2;
    i_addr = 64'h1000;
    exp_bus(1'b0, 64'h1000, '0, pat(8'hA5), 4);
    exp_rsp(1'b0, 1'b0, pat(8'hA5));
    chk("t1_h_rd_before", LW'(h_rd), '0);
    i_pend = 1; drive();
    @(posedge clk); #1;
    chk("t1_h_rd_next_cycle", LW'(h_rd), LW'(1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t1_i_dv_early", LW'(i_dv), '0);
    end
    @(posedge clk); #1;
    chk("t1_i_dv_pulse", LW'(i_dv), LW'(1));
    chk("t1_i_data", i_data, pat(8'hA5));
    @(posedge clk); #1;
    chk("t1_i_dv_single", LW'(i_dv), '0);
    drain(50);

    // Both readers from reset: I then D, then I,D,I,D
    do_reset();
    i_addr = 64'h3000; d_addr = 64'h4000;
    exp_bus(1'b0, 64'h3000, '0, pat(8'h11), 2); exp_rsp(1'b0, 1'b0, pat(8'h11));
    exp_bus(1'b0, 64'h4000, '0, pat(8'h22), 2); exp_rsp(1'b1, 1'b0, pat(8'h22));
    i_pend = 1; drp = 1; drive();
    drain(100);
    @(posedge clk); #2;
    exp_bus(1'b0, 64'h3000, '0, pat(8'h31), 1); exp_rsp(1'b0, 1'b0, pat(8'h31));
    exp_bus(1'b0, 64'h4000, '0, pat(8'h42), 2); exp_rsp(1'b1, 1'b0, pat(8'h42));
    exp_bus(1'b0, 64'h3000, '0, pat(8'h53), 3); exp_rsp(1'b0, 1'b0, pat(8'h53));
    exp_bus(1'b0, 64'h4000, '0, pat(8'h64), 1); exp_rsp(1'b1, 1'b0, pat(8'h64));
    i_pend = 2; drp = 2; drive();
    drain(200);

    // Writeback beats both refills; d_rdata untouched by the write
    @(posedge clk); #2;
    d_addr = 64'h2040; d_wdata = pat(8'h5C);
    exp_bus(1'b1, 64'h2040, pat(8'h5C), pat(8'hFF), 2); exp_rsp(1'b1, 1'b1, pat(8'h64));
    exp_bus(1'b0, 64'h3000, '0, pat(8'h77), 2);         exp_rsp(1'b0, 1'b0, pat(8'h77));
    exp_bus(1'b0, 64'h2040, '0, pat(8'h88), 2);         exp_rsp(1'b1, 1'b0, pat(8'h88));
    dwp = 1; drp = 1; i_pend = 1; drive();
    drain(200);

    // Spurious h_dv while idle
    do_reset();
    @(posedge clk); #2;
    spur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("t4_idle_quiet", LW'({i_dv, d_dv, h_rd, h_wr}), '0);
    end
    chk("t4_i_data_kept", i_data, '0);
    #1;
    i_addr = 64'h6000;
    exp_bus(1'b0, 64'h6000, '0, pat(8'h99), 1); exp_rsp(1'b0, 1'b0, pat(8'h99));
    i_pend = 1; drive();
    drain(50);

    // Reset two cycles into BUSY
    @(posedge clk); #2;
    i_addr = 64'h7000;
    exp_bus(1'b0, 64'h7000, '0, pat(8'hAB), 20); exp_rsp(1'b0, 1'b0, pat(8'hAB));
    i_pend = 1; drive();
    begin
      int n = 0;
      while (!h_rd && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk("t5_h_rd_seen", LW'(h_rd), LW'(1));
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_h_rd", LW'({h_rd, h_wr}), '0);
    chk("t5_rst_dv", LW'({i_dv, d_dv}), '0);
    do_reset();
    exp_bus(1'b0, 64'h7000, '0, pat(8'hCD), 2); exp_rsp(1'b0, 1'b0, pat(8'hCD));
    i_pend = 1; drive();
    drain(50);

    // Back-to-back L1i requests with no gap
    @(posedge clk); #2;
    i_addr = 64'h5000;
    exp_bus(1'b0, 64'h5000, '0, pat(8'h01), 1); exp_rsp(1'b0, 1'b0, pat(8'h01));
    exp_bus(1'b0, 64'h5000, '0, pat(8'h02), 1); exp_rsp(1'b0, 1'b0, pat(8'h02));
    exp_bus(1'b0, 64'h5000, '0, pat(8'h03), 1); exp_rsp(1'b0, 1'b0, pat(8'h03));
    i_pend = 3; drive();
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
